// File: rtl/decode_queue.sv
// Instruction queue between fetch and execute: buffers {pc, order, inst}
// and decodes the RV32I head entry combinationally for the execute stage.
module decode_queue #(
    parameter int DEPTH     = 4,
    parameter bit ENABLE_BR = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       imem_resp,
    input  logic [31:0]                imem_rdata,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [63:0]                in_order,
    output logic                       in_ready,
    input  logic                       flush,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [63:0]                out_order,
    output logic [31:0]                out_inst,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [4:0]                 out_rd,
    output logic [31:0]                out_imm,
    output logic                       out_regf_we,
    output logic                       out_mem_re,
    output logic                       out_mem_we,
    output logic                       out_is_br,
    output logic                       out_is_jal,
    output logic                       out_is_jalr,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [31:0]   r_pcMem    [DEPTH];
    logic [63:0]   r_orderMem [DEPTH];
    logic [31:0]   r_instMem  [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic        w_enq;
    logic        w_deq;
    logic [31:0] w_inst;
    logic        w_writesRd;
    logic [31:0] w_immI;
    logic [31:0] w_immS;
    logic [31:0] w_immB;
    logic [31:0] w_immU;
    logic [31:0] w_immJ;

    // A full queue refuses new entries even if the head leaves this cycle.
    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign w_enq     = in_valid & imem_resp & in_ready & ~flush;
    assign w_deq     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pcMem[r_tail]    <= in_pc;
            r_orderMem[r_tail] <= in_order;
            r_instMem[r_tail]  <= imem_rdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap falls out of the bit width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    assign out_pc    = r_pcMem[r_head];
    assign out_order = r_orderMem[r_head];
    assign w_inst    = r_instMem[r_head];
    assign out_inst  = w_inst;

    assign w_immI = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_immS = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_immB = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_immU = {w_inst[31:12], 12'b0};
    assign w_immJ = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    always_comb begin
        out_rs1     = '0;
        out_rs2     = '0;
        out_imm     = '0;
        out_mem_re  = 1'b0;
        out_mem_we  = 1'b0;
        out_is_br   = 1'b0;
        out_is_jal  = 1'b0;
        out_is_jalr = 1'b0;
        out_illegal = 1'b0;
        w_writesRd  = 1'b0;
        if (out_valid) begin
            case (w_inst[6:0])
                OP_LUI, OP_AUIPC: begin
                    w_writesRd = 1'b1;
                    out_imm    = w_immU;
                end
                OP_JAL: begin
                    if (ENABLE_BR) begin
                        w_writesRd = 1'b1;
                        out_is_jal = 1'b1;
                        out_imm    = w_immJ;
                    end else begin
                        out_illegal = 1'b1;
                    end
                end
                OP_JALR: begin
                    if (ENABLE_BR) begin
                        w_writesRd  = 1'b1;
                        out_is_jalr = 1'b1;
                        out_rs1     = w_inst[19:15];
                        out_imm     = w_immI;
                    end else begin
                        out_illegal = 1'b1;
                    end
                end
                OP_BRANCH: begin
                    if (ENABLE_BR) begin
                        out_is_br = 1'b1;
                        out_rs1   = w_inst[19:15];
                        out_rs2   = w_inst[24:20];
                        out_imm   = w_immB;
                    end else begin
                        out_illegal = 1'b1;
                    end
                end
                OP_LOAD: begin
                    w_writesRd = 1'b1;
                    out_mem_re = 1'b1;
                    out_rs1    = w_inst[19:15];
                    out_imm    = w_immI;
                end
                OP_STORE: begin
                    out_mem_we = 1'b1;
                    out_rs1    = w_inst[19:15];
                    out_rs2    = w_inst[24:20];
                    out_imm    = w_immS;
                end
                OP_IMM: begin
                    w_writesRd = 1'b1;
                    out_rs1    = w_inst[19:15];
                    out_imm    = w_immI;
                end
                OP_OP: begin
                    w_writesRd = 1'b1;
                    out_rs1    = w_inst[19:15];
                    out_rs2    = w_inst[24:20];
                end
                default: out_illegal = 1'b1;
            endcase
        end
        // Writes to x0 are architecturally discarded, so never enable them.
        out_rd      = w_writesRd ? w_inst[11:7] : 5'd0;
        out_regf_we = w_writesRd && (w_inst[11:7] != 5'd0);
    end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus randomized traffic, with a
// queue-based reference model and a scoreboard monitor covering two configs.
module tb_decode_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] order;
        logic [31:0] inst;
    } entryT;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        regfWe;
        logic        memRe;
        logic        memWe;
        logic        isBr;
        logic        isJal;
        logic        isJalr;
        logic        illegal;
    } decT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [63:0] in_order;
    logic        flush;
    logic        out_ready;

    logic        inReadyA, outValidA, inReadyB, outValidB;
    logic [31:0] outPcA, outInstA, outImmA, outPcB, outInstB, outImmB;
    logic [63:0] outOrderA, outOrderB;
    logic [4:0]  rs1A, rs2A, rdA, rs1B, rs2B, rdB;
    logic        weA, reA, mwA, brA, jalA, jalrA, illA;
    logic        weB, reB, mwB, brB, jalB, jalrB, illB;
    logic [2:0]  countA, countB;

    int nChecks = 0;
    int nPass   = 0;
    int mCount  = 0;
    entryT sb[$];

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH), .ENABLE_BR(1'b1)) dutA (
        .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .in_valid(in_valid), .in_pc(in_pc), .in_order(in_order), .in_ready(inReadyA),
        .flush(flush), .out_ready(out_ready), .out_valid(outValidA), .out_pc(outPcA),
        .out_order(outOrderA), .out_inst(outInstA), .out_rs1(rs1A), .out_rs2(rs2A),
        .out_rd(rdA), .out_imm(outImmA), .out_regf_we(weA), .out_mem_re(reA),
        .out_mem_we(mwA), .out_is_br(brA), .out_is_jal(jalA), .out_is_jalr(jalrA),
        .out_illegal(illA), .count(countA)
    );

    decode_queue #(.DEPTH(DEPTH), .ENABLE_BR(1'b0)) dutB (
        .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
        .in_valid(in_valid), .in_pc(in_pc), .in_order(in_order), .in_ready(inReadyB),
        .flush(flush), .out_ready(out_ready), .out_valid(outValidB), .out_pc(outPcB),
        .out_order(outOrderB), .out_inst(outInstB), .out_rs1(rs1B), .out_rs2(rs2B),
        .out_rd(rdB), .out_imm(outImmB), .out_regf_we(weB), .out_mem_re(reB),
        .out_mem_we(mwB), .out_is_br(brB), .out_is_jal(jalB), .out_is_jalr(jalrB),
        .out_illegal(illB), .count(countB)
    );

    // Reference decode built from instruction-format arithmetic.
    function automatic decT refDecode(input logic [31:0] w, input bit brEn);
        decT d;
        logic [6:0] op;
        bit isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore, isOpImm, isOp, writes;
        int imm;
        d = '0;
        op = w[6:0];
        isLui = (op == 7'h37); isAuipc = (op == 7'h17); isJal = (op == 7'h6F);
        isJalr = (op == 7'h67); isBranch = (op == 7'h63); isLoad = (op == 7'h03);
        isStore = (op == 7'h23); isOpImm = (op == 7'h13); isOp = (op == 7'h33);
        if (!(isLui || isAuipc || isJal || isJalr || isBranch || isLoad || isStore || isOpImm || isOp)
            || (!brEn && (isJal || isJalr || isBranch))) begin
            d.illegal = 1'b1;
            return d;
        end
        writes = isLui || isAuipc || isLoad || isOpImm || isOp || isJal || isJalr;
        if (isLoad || isStore || isOpImm || isOp || isJalr || isBranch) d.rs1 = w[19:15];
        if (isStore || isOp || isBranch) d.rs2 = w[24:20];
        if (writes) d.rd = w[11:7];
        d.regfWe = writes && (w[11:7] != 5'd0);
        d.memRe  = isLoad;
        d.memWe  = isStore;
        d.isBr   = isBranch;
        d.isJal  = isJal;
        d.isJalr = isJalr;
        imm = 0;
        if (isLoad || isOpImm || isJalr)
            imm = int'(w[30:20]) - (w[31] ? 2048 : 0);
        else if (isStore)
            imm = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
        else if (isBranch)
            imm = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
        else if (isLui || isAuipc)
            imm = int'(w[31:12]) * 4096;
        else if (isJal)
            imm = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
        d.imm = imm;
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic iv, input logic resp, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic [63:0] order,
                                 input logic ordy, input logic fl);
        in_valid   = iv;
        imem_resp  = resp;
        imem_rdata = inst;
        in_pc      = pc;
        in_order   = order;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue occupancy and contents in terms of accepted fetches.
    always @(posedge clk or negedge rst_n) begin
        bit enq, deq;
        if (!rst_n || flush) begin
            sb.delete();
            mCount = 0;
        end else begin
            deq = (mCount != 0) && out_ready;
            enq = in_valid && imem_resp && (mCount < DEPTH);
            if (enq) sb.push_back('{pc: in_pc, order: in_order, inst: imem_rdata});
            mCount = mCount + int'(enq) - int'(deq);
        end
    end

    // Monitor: compares status every cycle and the head entry whenever valid.
    always @(negedge clk) begin
        decT dA, dB, eA, eB;
        entryT head;
        checkOutput("countA", countA, mCount);
        checkOutput("countB", countB, mCount);
        checkOutput("in_readyA", inReadyA, mCount < DEPTH);
        checkOutput("out_validA", outValidA, mCount != 0);
        checkOutput("out_validB", outValidB, mCount != 0);
        dA = '{rs1A, rs2A, rdA, outImmA, weA, reA, mwA, brA, jalA, jalrA, illA};
        dB = '{rs1B, rs2B, rdB, outImmB, weB, reB, mwB, brB, jalB, jalrB, illB};
        if (outValidA) begin
            if (sb.size() == 0) begin
                checkOutput("scoreboard_nonempty", 0, 1);
            end else begin
                head = sb[0];
                eA = refDecode(head.inst, 1'b1);
                eB = refDecode(head.inst, 1'b0);
                checkOutput("headA", {outPcA, outOrderA, outInstA}, head);
                checkOutput("headB", {outPcB, outOrderB, outInstB}, head);
                checkOutput("decodeA", dA, eA);
                checkOutput("decodeB", dB, eB);
                if (out_ready && !flush) void'(sb.pop_front());
            end
        end else begin
            checkOutput("idle_ctrlA", {weA, reA, mwA, brA, jalA, jalrA, illA}, 0);
            checkOutput("idle_ctrlB", {weB, reB, mwB, brB, jalB, jalrB, illB}, 0);
        end
    end

    initial begin
        logic [31:0] opTable [12];
        logic [31:0] rnd;
        logic [31:0] rndPc;
        int orderCnt;
        opTable = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03,
                    32'h23, 32'h13, 32'h33, 32'h0F, 32'h73, 32'h7F};
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        @(negedge clk);
        checkOutput("reset_count", countA, 0);
        checkOutput("reset_in_ready", inReadyA, 1);
        tick;
        rst_n = 1'b1;

        // Fill with five fetches; the fifth must be dropped.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, 32'h00108093, 32'h1000 + 32'(4 * k), 64'(k), 0, 0);
            tick;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("fill_count", countA, 4);
        checkOutput("fill_in_ready", inReadyA, 0);
        checkOutput("fill_head_order", outOrderA, 0);
        tick;

        // Full queue with dequeue: new fetch still refused.
        applyStimulus(1, 1, 32'h00108093, 32'h2000, 64'd99, 1, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("full_deq_count", countA, 3);
        checkOutput("full_deq_head_order", outOrderA, 1);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        repeat (4) tick;

        // Streaming: one entry in flight, order advancing every cycle.
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1, 1, 32'h00208113, 32'h3000 + 32'(4 * i), 64'(100 + i), 1, 0);
            if (i > 0) begin
                @(negedge clk);
                checkOutput("stream_count", countA, 1);
                checkOutput("stream_order", outOrderA, 64'(100 + i - 1));
            end
            tick;
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        tick;

        // Flush overrides a same-cycle enqueue.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 1, 32'h00000033, 32'h4000, 64'(150 + k), 0, 0);
            tick;
        end
        applyStimulus(1, 1, 32'h00000033, 32'h4000, 64'd160, 1, 1);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("flush_count", countA, 0);
        checkOutput("flush_out_valid", outValidA, 0);
        tick;

        // Directed decodes: addi x0,x1,5 / sw x2,-4(x3) / jal x1,16.
        applyStimulus(1, 1, 32'h00508013, 32'h5000, 64'd200, 0, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("addi_regf_we", weA, 0);
        checkOutput("addi_rs1", rs1A, 1);
        checkOutput("addi_imm", outImmA, 5);
        tick;
        applyStimulus(1, 1, 32'hFE21AE23, 32'h5004, 64'd201, 1, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("sw_mem_we", mwA, 1);
        checkOutput("sw_imm", outImmA, 32'hFFFFFFFC);
        checkOutput("sw_rs2", rs2A, 2);
        tick;
        applyStimulus(1, 1, 32'h010000EF, 32'h5008, 64'd202, 1, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("jal_is_jal", jalA, 1);
        checkOutput("jal_imm", outImmA, 16);
        checkOutput("nobr_illegal", illB, 1);
        checkOutput("nobr_is_jal", jalB, 0);
        checkOutput("nobr_regf_we", weB, 0);
        tick;
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        tick;

        // Reset in the middle of operation discards entries immediately.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 1, 32'h00000037, 32'h6000, 64'(300 + k), 0, 0);
            tick;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1 checkOutput("async_reset_count", countA, 0);
        checkOutput("async_reset_out_valid", outValidA, 0);
        tick;
        rst_n = 1'b1;

        // Randomized traffic with occasional flush and reset.
        orderCnt = 1000;
        for (int c = 0; c < 600; c++) begin
            rnd   = $urandom;
            rndPc = $urandom;
            applyStimulus(($urandom % 4) != 0, ($urandom % 4) != 0,
                          {rnd[31:7], opTable[$urandom % 12][6:0]}, rndPc,
                          {32'($urandom), 32'(orderCnt)}, ($urandom % 2) != 0,
                          ($urandom % 32) == 0);
            orderCnt++;
            rst_n = (($urandom % 150) != 0);
            tick;
            rst_n = 1'b1;
        end
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        repeat (6) tick;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of instruction-queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter ENABLE_BR, default 1, meaning decode of jal/jalr/branch is enabled (0 treats them as illegal).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port imem_resp, input, 1 bit: imem_rdata is valid this cycle.
REQ-006 The block SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-007 The block SHALL have port in_valid, input, 1 bit: fetch-side pc and order are valid.
REQ-008 The block SHALL have port in_pc, input, 32 bits: pc of the fetched instruction.
REQ-009 The block SHALL have port in_order, input, 64 bits: retirement order tag.
REQ-010 The block SHALL have port in_ready, output, 1 bit: queue accepts an entry this cycle.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all queued entries.
REQ-012 The block SHALL have port out_ready, input, 1 bit: execute stage consumes the head entry.
REQ-013 The block SHALL have port out_valid, output, 1 bit: head entry valid.
REQ-014 The block SHALL have ports out_pc (32), out_order (64), out_inst (32), outputs: head-entry fields.
REQ-015 The block SHALL have ports out_rs1, out_rs2, out_rd, outputs, 5 bits each: decoded register indices.
REQ-016 The block SHALL have port out_imm, output, 32 bits: sign-extended immediate for the decoded format.
REQ-017 The block SHALL have ports out_regf_we, out_mem_re, out_mem_we, out_is_br, out_is_jal, out_is_jalr, out_illegal, outputs, 1 bit each: decoded controls.
REQ-018 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-019 Enqueue SHALL occur when in_valid && imem_resp && in_ready && !flush, storing {in_pc, in_order, imem_rdata} at the tail.
REQ-020 in_ready SHALL equal (count < DEPTH); a dequeue in the same cycle SHALL NOT make a full queue accept.
REQ-021 imem_resp without in_valid, or with in_ready low, SHALL be dropped with no state change.
REQ-022 out_valid SHALL equal (count != 0); dequeue occurs when out_valid && out_ready && !flush.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-024 Head and tail pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Latency SHALL be one cycle: an entry enqueued at edge N is visible on out_* from cycle N+1.
REQ-026 flush SHALL, at the next edge, set count and both pointers to 0, overriding any same-cycle enqueue or dequeue.
REQ-027 Decode SHALL be combinational from the head entry; when out_valid=0, all decoded controls SHALL be 0.
REQ-028 out_imm SHALL be I-format for load/op-imm/jalr, S for store, B for branch, U for lui/auipc, J for jal, otherwise 0.
REQ-029 out_rs1 SHALL be inst[19:15] for load, store, op-imm, op, jalr, branch; otherwise 0.
REQ-030 out_rs2 SHALL be inst[24:20] for store, op, branch; otherwise 0.
REQ-031 out_regf_we SHALL be 1 for lui, auipc, load, op-imm, op, jal, jalr, and forced to 0 when rd = 0.
REQ-032 out_mem_re SHALL be 1 only for load; out_mem_we SHALL be 1 only for store.
REQ-033 out_is_br, out_is_jal, out_is_jalr SHALL flag their opcodes when ENABLE_BR=1, and SHALL be 0 when ENABLE_BR=0.
REQ-034 out_illegal SHALL be 1 for any unlisted opcode (or a branch opcode with ENABLE_BR=0); all other controls SHALL then be 0.

Reset
REQ-035 While rst_n=0: count=0, pointers=0, out_valid=0, in_ready=1, all decoded controls 0; reset mid-operation discards all entries immediately.
REQ-036 Queue storage SHALL NOT require reset; out_pc, out_order, out_inst are don't-care while out_valid=0.

Verification
REQ-037 Fill: DEPTH=4, out_ready=0, 5 fetches -> count=4, in_ready=0 after 4th, 5th dropped, order 0..3 preserved.
REQ-038 Full with dequeue: count=4, out_ready=1, new fetch -> fetch dropped, count=3 next cycle.
REQ-039 Streaming: in_valid/imem_resp/out_ready all high for 10 cycles -> count stays 1, out_order increments by 1 per cycle.
REQ-040 Flush: count=3 plus same-cycle enqueue and flush=1 -> count=0, out_valid=0 next cycle.
REQ-041 Decode: addi x0,x1,5 (0x00508013) -> out_regf_we=0, out_rs1=1, out_imm=5; sw x2,-4(x3) -> out_mem_we=1, out_imm=0xFFFFFFFC.
REQ-042 ENABLE_BR=0, jal x1,16 (0x010000EF) -> out_illegal=1, out_is_jal=0, out_regf_we=0.
